// File: rtl/mem_data_bytewise.sv
// Byte-addressed RV32I data memory for the MEM stage, with a sequential post-reset clear.
// Optional fault capture is enabled by defining MEM_DATA_FAULT_LATCH_EN.
module mem_data_bytewise #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0C00,
  parameter int          DEPTH_WORDS = 256,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_memwrite,
  input  logic        i_memread,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
`ifdef MEM_DATA_FAULT_LATCH_EN
  input  logic        i_fault_clr,
  output logic        o_fault_valid,
  output logic [31:0] o_fault_addr,
  output logic        o_fault_is_store,
`endif
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_misaligned,
  output logic        o_out_of_range,
  output logic        o_dbg_state
);

  // Handshake: a request (memread/memwrite) is honoured only in a cycle where
  // o_ready=1; there is no backpressure, requests seen while o_ready=0 are dropped.

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       off;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  logic              in_range;
  logic              size_fault;
  logic              req;
  logic              st_en;
  logic              ld_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign off      = i_address - BASE_ADDR;
  assign widx     = off[IDX_W+1:2];
  assign lane     = off[1:0];
  assign in_range = ({1'b0, i_address} >= {1'b0, BASE_ADDR}) && ({1'b0, i_address} < END_ADDR);
  assign req      = i_memread | i_memwrite;

  always_comb begin
    size_fault = 1'b1;
    case (i_funct3)
      3'b000, 3'b100: size_fault = 1'b0;
      3'b001, 3'b101: size_fault = i_address[0];
      3'b010:         size_fault = (i_address[1:0] != 2'b00);
      default:        size_fault = 1'b1;
    endcase
  end

  assign o_misaligned   = req & size_fault;
  assign o_out_of_range = req & ~in_range;
  assign st_en          = i_memwrite & ~size_fault & in_range & (state == ST_RUN);
  assign ld_en          = i_memread  & ~size_fault & in_range & (state == ST_RUN);
  assign o_dbg_state    = state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            state   <= ST_RUN;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = i_write_data;
    case (i_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_write_data[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rword = mem[widx];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  always_comb begin
    o_read_data = '0;
    if (ld_en) begin
      case (i_funct3)
        3'b000:  o_read_data = {{24{rbyte[7]}}, rbyte};
        3'b001:  o_read_data = {{16{rhalf[15]}}, rhalf};
        3'b010:  o_read_data = rword;
        3'b100:  o_read_data = {24'd0, rbyte};
        3'b101:  o_read_data = {16'd0, rhalf};
        default: o_read_data = '0;
      endcase
    end
  end

`ifdef MEM_DATA_FAULT_LATCH_EN
  // First fault sticks until cleared; a clear in the same cycle as a new fault wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fault_valid    <= 1'b0;
      o_fault_addr     <= '0;
      o_fault_is_store <= 1'b0;
    end else if (i_fault_clr) begin
      o_fault_valid <= 1'b0;
    end else if ((state == ST_RUN) && (o_misaligned || o_out_of_range) && !o_fault_valid) begin
      o_fault_valid    <= 1'b1;
      o_fault_addr     <= i_address;
      o_fault_is_store <= i_memwrite;
    end
  end
`endif

endmodule

// File: tb/tb_mem_data_bytewise.sv
// Directed plus randomised bench for mem_data_bytewise (default parameters).
// Fault-capture checks are compiled in when MEM_DATA_FAULT_LATCH_EN is defined.
module tb_mem_data_bytewise;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_memwrite;
  logic        i_memread;
  logic [2:0]  i_funct3;
  logic [31:0] i_address;
  logic [31:0] i_write_data;
  logic [31:0] o_read_data;
  logic        o_ready;
  logic        o_misaligned;
  logic        o_out_of_range;
  logic        o_dbg_state;
`ifdef MEM_DATA_FAULT_LATCH_EN
  logic        i_fault_clr;
  logic        o_fault_valid;
  logic [31:0] o_fault_addr;
  logic        o_fault_is_store;
`endif

  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [256];
  int n_vec  = 0;
  int n_fail = 0;

  mem_data_bytewise dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_memwrite     (i_memwrite),
    .i_memread      (i_memread),
    .i_funct3       (i_funct3),
    .i_address      (i_address),
    .i_write_data   (i_write_data),
`ifdef MEM_DATA_FAULT_LATCH_EN
    .i_fault_clr    (i_fault_clr),
    .o_fault_valid  (o_fault_valid),
    .o_fault_addr   (o_fault_addr),
    .o_fault_is_store(o_fault_is_store),
`endif
    .o_read_data    (o_read_data),
    .o_ready        (o_ready),
    .o_misaligned   (o_misaligned),
    .o_out_of_range (o_out_of_range),
    .o_dbg_state    (o_dbg_state)
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (vectors=%0d)", n_vec);
    $fatal(1, "watchdog expired");
  end

  // Reference model
  function automatic void clear_model();
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = int'((a - 32'h0C00) >> 2);
    case (f3[1:0])
      2'b00:   ref_mem[k][8*int'(a[1:0]) +: 8] = wd[7:0];
      2'b01:   ref_mem[k][16*int'(a[1]) +: 16] = wd[15:0];
      default: ref_mem[k] = wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[int'((a - 32'h0C00) >> 2)];
    b = w[8*int'(a[1:0]) +: 8];
    h = w[16*int'(a[1]) +: 16];
    case (f3)
      F_B:     return {{24{b[7]}}, b};
      F_H:     return {{16{h[15]}}, h};
      F_BU:    return {24'd0, b};
      F_HU:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Scoreboard compare: pops the oldest expectation
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    expv = exp_q.pop_front();
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: drive one cycle of request after an edge, check outputs mid-cycle
  task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rd, input logic e_mis, input logic e_oor,
                       input logic e_rdy);
    @(posedge i_clk);
    #1;
    i_memread    = rd;
    i_memwrite   = wr;
    i_funct3     = f3;
    i_address    = a;
    i_write_data = wd;
    exp_q.push_back(e_rd);
    exp_q.push_back({31'd0, e_mis});
    exp_q.push_back({31'd0, e_oor});
    exp_q.push_back({31'd0, e_rdy});
    @(negedge i_clk);
    check("read_data", o_read_data);
    check("misaligned", {31'd0, o_misaligned});
    check("out_of_range", {31'd0, o_out_of_range});
    check("ready", {31'd0, o_ready});
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    apply(1'b0, 1'b1, f3, a, wd, 32'd0, 1'b0, 1'b0, 1'b1);
    model_store(f3, a, wd);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e);
    apply(1'b1, 1'b0, f3, a, 32'd0, e, 1'b0, 1'b0, 1'b1);
  endtask

  // Reads at 0xC00 through a clear; ready must rise only after the 256th edge
  task automatic clear_run(input int n);
    for (int i = 1; i <= n; i++)
      apply(1'b1, 1'b0, F_W, 32'h0C00, 32'd0, 32'd0, 1'b0, 1'b0, (i == 256));
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_memread    = 1'b1;
    i_memwrite   = 1'b0;
    i_funct3     = F_W;
    i_address    = 32'h0C00;
    i_write_data = 32'd0;
`ifdef MEM_DATA_FAULT_LATCH_EN
    i_fault_clr  = 1'b0;
`endif
    clear_model();

    // Reset state
    repeat (3) apply(1'b1, 1'b0, F_W, 32'h0C00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    clear_run(256);
    load(F_W, 32'h0C00, 32'h0000_0000);

    // Sized stores and sign/zero-extended loads
    store(F_W, 32'h0C10, 32'h1122_3344);
    store(F_B, 32'h0C12, 32'hFFFF_FFAB);
    load(F_W,  32'h0C10, 32'h11AB_3344);
    load(F_B,  32'h0C12, 32'hFFFF_FFAB);
    load(F_BU, 32'h0C12, 32'h0000_00AB);
    store(F_W, 32'h0C14, 32'hDEAD_BEEF);
    store(F_H, 32'h0C16, 32'h0000_8001);
    load(F_H,  32'h0C16, 32'hFFFF_8001);
    load(F_HU, 32'h0C16, 32'h0000_8001);
    load(F_W,  32'h0C14, 32'h8001_BEEF);
    load(F_B,  32'h0C17, 32'hFFFF_FF80);
    load(F_HU, 32'h0C14, 32'h0000_BEEF);

    // Read and write same address: old data now, new data next cycle
    apply(1'b1, 1'b1, F_W, 32'h0C10, 32'hCAFE_F00D, 32'h11AB_3344, 1'b0, 1'b0, 1'b1);
    model_store(F_W, 32'h0C10, 32'hCAFE_F00D);
    load(F_W, 32'h0C10, 32'hCAFE_F00D);

    // Misalignment and illegal width codes
    apply(1'b0, 1'b1, F_W, 32'h0C21, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    load(F_W, 32'h0C20, 32'h0000_0000);
    apply(1'b1, 1'b0, F_H,  32'h0C23, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, F_W,  32'h0C12, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 3'b011, 32'h0C10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 3'b110, 32'h0C10, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
    load(F_W, 32'h0C10, 32'hCAFE_F00D);

    // Window boundaries, no aliasing of out-of-range stores
    apply(1'b1, 1'b0, F_W, 32'h0BFC, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, F_W, 32'h1000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, F_W, 32'hFFFF_FC00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b1, F_W, 32'h1000, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b1);
    load(F_W, 32'h0C00, 32'h0000_0000);
    store(F_W, 32'h0FFC, 32'h7654_3210);
    load(F_W, 32'h0FFC, 32'h7654_3210);

    // No request: flags stay low even for bad address and code
    apply(1'b0, 1'b0, 3'b111, 32'h0000_1001, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Random word stores then random sized loads against the model
    for (int i = 0; i < 32; i++)
      store(F_W, 32'h0C00 + (32'($urandom_range(0, 255)) << 2), $urandom);
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       f3 = F_B;
        1:       f3 = F_H;
        2:       f3 = F_W;
        3:       f3 = F_BU;
        default: f3 = F_HU;
      endcase
      a = 32'h0C00 + (32'($urandom_range(0, 255)) << 2);
      if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      load(f3, a, model_load(f3, a));
    end

    // Reset mid-clear restarts from index 0
    store(F_W, 32'h0C40, 32'h5A5A_5A5A);
    load(F_W, 32'h0C40, 32'h5A5A_5A5A);
    @(posedge i_clk);
    #1 i_reset_n = 1'b0;
    apply(1'b1, 1'b0, F_W, 32'h0C00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    clear_run(100);
    #1 i_reset_n = 1'b0;
    #2 i_reset_n = 1'b1;
    clear_run(256);
    clear_model();
    load(F_W, 32'h0C40, 32'h0000_0000);
    load(F_W, 32'h0C10, 32'h0000_0000);

`ifdef MEM_DATA_FAULT_LATCH_EN
    // Fault capture: first fault sticks, clear wins over a same-cycle fault
    exp_q.push_back(32'd0);
    check("fault_valid_idle", {31'd0, o_fault_valid});
    apply(1'b0, 1'b1, F_W, 32'h0C02, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, F_W, 32'h2000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(32'd1);
    check("fault_valid", {31'd0, o_fault_valid});
    exp_q.push_back(32'h0C02);
    check("fault_addr", o_fault_addr);
    exp_q.push_back(32'd1);
    check("fault_is_store", {31'd0, o_fault_is_store});
    i_fault_clr = 1'b1;
    load(F_W, 32'h0C00, 32'd0);
    exp_q.push_back(32'd0);
    check("fault_clr_wins", {31'd0, o_fault_valid});
    i_fault_clr = 1'b0;
    apply(1'b1, 1'b0, F_W, 32'h0C03, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    load(F_W, 32'h0C00, 32'd0);
    exp_q.push_back(32'd1);
    check("fault_valid2", {31'd0, o_fault_valid});
    exp_q.push_back(32'h0C03);
    check("fault_addr2", o_fault_addr);
    exp_q.push_back(32'd0);
    check("fault_is_store2", {31'd0, o_fault_is_store});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
